// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter built from WIDTH toggle flip-flops.
// Define TFF_MOD_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;
`ifndef TFF_MOD_COUNTER_SAT_EN
  logic             wrap_q;
  logic             wrap_d;
`endif

  assign at_max  = (q_q == MAX);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d = q_q;
`ifndef TFF_MOD_COUNTER_SAT_EN
    wrap_d = 1'b0;
`endif
    if (load) begin
      q_d = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
`ifdef TFF_MOD_COUNTER_SAT_EN
          q_d = MAX;
`else
          q_d    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_zero) begin
`ifdef TFF_MOD_COUNTER_SAT_EN
          q_d = '0;
`else
          q_d    = MAX;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  // Toggle vector: each bit flips only where the requested state differs.
  assign t = q_q ^ q_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_q ^ t;
    end
  end

`ifdef TFF_MOD_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

  assign q    = q_q;
  assign qbar = ~q_q;
  assign tc   = en & (up ? at_max : at_zero);

endmodule

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - vector-table bench for tff_mod_counter at WIDTH=4, MODULUS=10.
module tb_tff_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             up = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] lv;
    logic             chk_tc;
    logic             tc;
    logic [WIDTH-1:0] q;
    logic             wrap;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input int lv, input logic chk, input logic etc,
                     input int eq, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = WIDTH'(lv);
    v.chk_tc = chk; v.tc = etc; v.q = WIDTH'(eq); v.wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic cnt(input logic e, input logic u, input logic etc, input int eq, input logic ew);
    add(1'b1, e, u, 1'b0, 0, 1'b1, etc, eq, ew);
  endtask

  task automatic ld(input int lv, input logic e, input logic u, input logic etc, input int eq);
    add(1'b1, e, u, 1'b1, lv, 1'b1, etc, eq, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   pre;
    int   post;

    // Reset overrides load and en
    add(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 0, 1'b0);

    // Up count from 0 for 12 edges
    for (int k = 0; k < 12; k++) begin
`ifdef TFF_MOD_COUNTER_SAT_EN
      pre  = (k < 9) ? k : 9;
      post = (k + 1 < 9) ? k + 1 : 9;
      cnt(1'b1, 1'b1, pre == 9, post, 1'b0);
`else
      pre  = k % MODULUS;
      post = (k + 1) % MODULUS;
      cnt(1'b1, 1'b1, pre == 9, post, pre == 9);
`endif
    end

    // Down count through zero
    ld(1, 1'b0, 1'b0, 1'b0, 1);
`ifdef TFF_MOD_COUNTER_SAT_EN
    cnt(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cnt(1'b1, 1'b0, 1'b1, 0, 1'b0);
    cnt(1'b1, 1'b0, 1'b1, 0, 1'b0);
`else
    cnt(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cnt(1'b1, 1'b0, 1'b1, 9, 1'b1);
    cnt(1'b1, 1'b0, 1'b0, 8, 1'b0);
`endif

    // Load precedence, clamp, load while tc=1
    ld(3, 1'b1, 1'b1, 1'b0, 3);
    ld(13, 1'b1, 1'b1, 1'b0, 9);
    ld(4, 1'b1, 1'b1, 1'b1, 4);
    ld(10, 1'b0, 1'b1, 1'b0, 9);
    ld(5, 1'b0, 1'b1, 1'b0, 5);

    // Hold, then direction flip every edge
    for (int k = 0; k < 4; k++) cnt(1'b0, 1'b1, 1'b0, 5, 1'b0);
    cnt(1'b1, 1'b1, 1'b0, 6, 1'b0);
    cnt(1'b1, 1'b0, 1'b0, 5, 1'b0);
    cnt(1'b1, 1'b1, 1'b0, 6, 1'b0);
    cnt(1'b1, 1'b0, 1'b0, 5, 1'b0);

    // Reset on the wrapping edge suppresses the wrap pulse
    ld(9, 1'b0, 1'b1, 1'b0, 9);
    add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0);
    cnt(1'b1, 1'b1, 1'b0, 1, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      en       = vecs[i].en;
      up       = vecs[i].up;
      load     = vecs[i].load;
      load_val = vecs[i].lv;
      #1;
      if (vecs[i].chk_tc) check("tc", i, WIDTH'(tc), WIDTH'(vecs[i].tc));
      sb.push_back('{q: vecs[i].q, wrap: vecs[i].wrap});
      n_vec++;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard vec %0d: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        check("q", i, q, e.q);
        check("qbar", i, qbar, ~e.q);
        check("wrap", i, WIDTH'(wrap), WIDTH'(e.wrap));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
